// File: rtl/systolic_result_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_packer_pkg
// Brief    : Shared widths and helpers for the systolic result packer slice.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_result_packer_pkg;

    localparam int PIX_W             = 24;
    localparam int PIX_PER_BLK       = 16;
    localparam int BLK_W             = PIX_W * PIX_PER_BLK;
    localparam int AXIS_W            = 32;
    localparam int DEF_ARRAY_LATENCY = 2;
    localparam int PIX_CNT_W         = $clog2(PIX_PER_BLK);

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [BLK_W-1:0] block_t;

    // Extract pixel idx from a packed result block (pixel k at bits 24k+23:24k)
    function automatic pixel_t blk_pixel(input block_t blk, input logic [PIX_CNT_W-1:0] idx);
        return blk[int'(idx) * PIX_W +: PIX_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_result_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_packer_fifo
// Brief    : Synchronous block FIFO with asynchronous-read storage. The caller
//            only pushes when there is room (or a pop in the same cycle) and
//            only pops when non-empty.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_result_packer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 384
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    // Storage write; no reset so the array maps onto distributed RAM
    always_ff @(posedge aclk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign occ       = r_occ;

endmodule
`default_nettype wire

// File: rtl/systolic_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_packer
// Brief    : Buffers 16x24-bit systolic result blocks and serialises them onto
//            an AXI4-Stream master, one pixel per beat, with credit-based
//            array_ready toward the pixel feeder and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_result_packer
    import systolic_result_packer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int ARRAY_LATENCY  = DEF_ARRAY_LATENCY,
    parameter int BLOCKS_PER_PKT = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              pixel_valid,
    output logic              array_ready,
    input  logic [BLK_W-1:0]  result,
    input  logic              result_valid,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              overflow
);

    localparam int OCC_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int BLK_CNT_W = (BLOCKS_PER_PKT > 1) ? $clog2(BLOCKS_PER_PKT) : 1;
    localparam int SUM_W     = OCC_W + $clog2(ARRAY_LATENCY + 1) + 1;

    localparam logic [PIX_CNT_W-1:0] c_LAST_PIX = PIX_CNT_W'(PIX_PER_BLK - 1);
    localparam logic [BLK_CNT_W-1:0] c_LAST_BLK = BLK_CNT_W'(BLOCKS_PER_PKT - 1);

    logic [PIX_CNT_W-1:0]     r_pix_cnt;
    logic [BLK_CNT_W-1:0]     r_blk_cnt;
    logic [ARRAY_LATENCY-1:0] r_pv_sr;
    logic                     r_overflow;

    logic [OCC_W-1:0] w_occ;
    block_t           w_head;
    logic             w_tvalid;
    logic             w_hs;
    logic             w_last_pix;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic [SUM_W-1:0] w_inflight;
    logic [SUM_W-1:0] w_commit;

    assign w_tvalid   = (w_occ != '0);
    assign w_hs       = w_tvalid && m_axis_tready;
    assign w_last_pix = (r_pix_cnt == c_LAST_PIX);
    assign w_pop      = w_hs && w_last_pix;
    assign w_full     = (w_occ == OCC_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the incoming block needs
    assign w_push     = result_valid && (!w_full || w_pop);

    systolic_result_packer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BLK_W)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (w_push),
        .push_data (result),
        .pop       (w_pop),
        .head_data (w_head),
        .occ       (w_occ)
    );

    // Pixel index within the head block and block index within the packet
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_pix_cnt <= '0;
            r_blk_cnt <= '0;
        end else if (w_hs) begin
            if (w_last_pix) begin
                r_pix_cnt <= '0;
                r_blk_cnt <= (r_blk_cnt == c_LAST_BLK) ? '0 : r_blk_cnt + BLK_CNT_W'(1);
            end else begin
                r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
            end
        end
    end

    // Sticky overflow: a block arrived with no room and no simultaneous pop
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_overflow <= 1'b0;
        end else if (result_valid && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // Track pixel strobes still travelling through the array
    generate
        if (ARRAY_LATENCY > 1) begin : g_pv_multi
            always_ff @(posedge aclk) begin
                if (!aresetn) r_pv_sr <= '0;
                else          r_pv_sr <= {r_pv_sr[ARRAY_LATENCY-2:0], pixel_valid};
            end
        end else begin : g_pv_single
            always_ff @(posedge aclk) begin
                if (!aresetn) r_pv_sr <= '0;
                else          r_pv_sr <= pixel_valid;
            end
        end
    endgenerate

    // Count in-flight blocks; ready only if buffered plus in-flight leaves room
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ARRAY_LATENCY; i++) begin
            w_inflight = w_inflight + SUM_W'(r_pv_sr[i]);
        end
        w_commit = SUM_W'(w_occ) + w_inflight;
    end

    assign array_ready   = (w_commit < SUM_W'(FIFO_DEPTH));
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tdata  = w_tvalid ? {{(AXIS_W-PIX_W){1'b0}}, blk_pixel(w_head, r_pix_cnt)} : '0;
    assign m_axis_tlast  = w_tvalid && w_last_pix && (r_blk_cnt == c_LAST_BLK);
    assign overflow      = r_overflow;

endmodule
`default_nettype wire
